sisc_mem_arb: RTL

Single-port memory arbiter for the SISC processor. Shares one synchronous memory between the instruction-fetch requester, driven from the ctrl fetch state, and the data requester, driven by LOD/STR/SWP in the mem state. It serialises accesses with a req/ack handshake, latches the address and write data at grant, and returns read data with a one-cycle ack pulse.

---
 rtl/sisc_mem_arb_if.sv | 37 +++
 rtl/sisc_mem_arb.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/sisc_mem_arb_if.sv
// Request/memory bus bundle for sisc_mem_arb: fetch and data requester ports,
// the single-port memory port and the busy flag.
interface sisc_mem_arb_if #(
  parameter int AW = 16,
  parameter int DW = 32
) ();
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  // Requesters and memory side
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/sisc_mem_arb.sv
// Single-port memory arbiter between SISC fetch (IF) and data (DM) requesters.
// Optional macro SISC_MEM_ARB_RR_EN: round-robin on conflict instead of DM-first.
module sisc_mem_arb #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  sisc_mem_arb_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  localparam logic [2:0] LAT3 = 3'(MEM_LAT);

  state_e        state_q,     state_d;
  logic          owner_q,     owner_d;
  logic [2:0]    cnt_q,       cnt_d;
  logic          we_q,        we_d;
  logic [AW-1:0] addr_q,      addr_d;
  logic [DW-1:0] wdata_q,     wdata_d;
  logic          mem_en_q,    mem_en_d;
  logic          mem_we_q,    mem_we_d;
  logic          if_ack_q,    if_ack_d;
  logic          dm_ack_q,    dm_ack_d;
  logic [DW-1:0] if_rdata_q,  if_rdata_d;
  logic [DW-1:0] dm_rdata_q,  dm_rdata_d;
  logic          busy_q,      busy_d;

  logic grant;
  logic pick_dm;

  assign grant = (state_q == IDLE) && (bus.if_req || bus.dm_req);

`ifdef SISC_MEM_ARB_RR_EN
  logic last_q, last_d;

  // last_q: 0 = IF served last, 1 = DM; the other side wins a conflict
  assign pick_dm = bus.dm_req && (!bus.if_req || !last_q);

  always_comb begin
    last_d = last_q;
    if (grant) last_d = pick_dm;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b0;
    else     last_q <= last_d;
  end
`else
  assign pick_dm = bus.dm_req;
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mem_en_d   = 1'b0;
    mem_we_d   = 1'b0;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (grant) begin
          owner_d  = pick_dm;
          addr_d   = pick_dm ? bus.dm_addr : bus.if_addr;
          we_d     = pick_dm && bus.dm_we;
          wdata_d  = pick_dm ? bus.dm_wdata : '0;
          cnt_d    = LAT3;
          mem_en_d = 1'b1;
          mem_we_d = pick_dm && bus.dm_we;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        // Counting starts after the strobe cycle so the cnt==1 edge lines up
        // with mem_rdata being valid MEM_LAT cycles after mem_en.
        if (!mem_en_q) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            if (!we_q) begin
              if (owner_q) dm_rdata_d = bus.mem_rdata;
              else         if_rdata_d = bus.mem_rdata;
            end
            if_ack_d = !owner_q;
            dm_ack_d = owner_q;
            state_d  = RESP;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.busy      = busy_q;

endmodule
